// File: rtl/mips_pkg.sv
// Shared types and constants for the multi-cycle MIPS control unit and its ALU.
package mips_pkg;

   // ALU operation codes, shared with the ALU
   typedef enum logic [3:0] {
      AluAnd = 4'b0000,
      AluOr  = 4'b0001,
      AluAdd = 4'b0010,
      AluSub = 4'b0110,
      AluSlt = 4'b0111,
      AluNor = 4'b1100
   } alu_op_e;

   // Control FSM states
   typedef enum logic [2:0] {
      StFetch  = 3'd0,
      StDecode = 3'd1,
      StExec   = 3'd2,
      StMem    = 3'd3,
      StWb     = 3'd4,
      StHalt   = 3'd5
   } state_e;

   // Opcodes (instr[31:26])
   localparam logic [5:0] OpRtype = 6'b000000;
   localparam logic [5:0] OpJ     = 6'b000010;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpBne   = 6'b000101;
   localparam logic [5:0] OpAddiu = 6'b001001;
   localparam logic [5:0] OpSlti  = 6'b001010;
   localparam logic [5:0] OpAndi  = 6'b001100;
   localparam logic [5:0] OpOri   = 6'b001101;
   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;

   // Funct codes (instr[5:0]) for R-type
   localparam logic [5:0] FnJr    = 6'b001000;
   localparam logic [5:0] FnAddu  = 6'b100001;
   localparam logic [5:0] FnSubu  = 6'b100011;
   localparam logic [5:0] FnAnd   = 6'b100100;
   localparam logic [5:0] FnOr    = 6'b100101;
   localparam logic [5:0] FnNor   = 6'b100111;
   localparam logic [5:0] FnSlt   = 6'b101010;

   // ALU B-operand select codes
   localparam logic [1:0] SrcBRegB  = 2'd0;
   localparam logic [1:0] SrcBFour  = 2'd1;
   localparam logic [1:0] SrcBImm   = 2'd2;
   localparam logic [1:0] SrcBImmSh = 2'd3;

   // PC source select codes
   localparam logic [1:0] PcSrcAlu    = 2'd0;
   localparam logic [1:0] PcSrcAluOut = 2'd1;
   localparam logic [1:0] PcSrcJump   = 2'd2;
   localparam logic [1:0] PcSrcRegA   = 2'd3;

endpackage

// File: rtl/mips_control_fsm_if.sv
// ALU and memory-bus handshake signals between the control unit and the datapath.
interface mips_control_fsm_if;

   logic [3:0] alu_operation;
   logic       zero;
   logic       read;
   logic       write;
   logic       waitrequest;

   // Control unit side: drives ALU op and memory strobes
   modport master (
      output alu_operation,
      output read,
      output write,
      input  zero,
      input  waitrequest
   );

   // Datapath side: ALU and memory
   modport slave (
      input  alu_operation,
      input  read,
      input  write,
      output zero,
      output waitrequest
   );

endinterface

// File: rtl/alu_op_decoder.sv
// Maps an R-type funct field onto the ALU operation; flags unsupported functs.
module alu_op_decoder
   import mips_pkg::*;
(
   input  logic [5:0] funct,
   output alu_op_e    op,
   output logic       valid
);

   // Funct to ALU op lookup
   always_comb begin
      op    = AluAdd;
      valid = 1'b1;
      case (funct)
         FnAddu:  op = AluAdd;
         FnSubu:  op = AluSub;
         FnAnd:   op = AluAnd;
         FnOr:    op = AluOr;
         FnNor:   op = AluNor;
         FnSlt:   op = AluSlt;
         default: valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/mips_control_fsm.sv
// Multi-cycle MIPS control unit: fetch/decode/exec/mem/wb sequencing with memory stalls.
module mips_control_fsm
   import mips_pkg::*;
#(
   parameter bit RESET_VECTOR_ZERO_HALT = 1'b1
) (
   input  logic                       clk,
   input  logic                       reset,
   mips_control_fsm_if.master         bus,
   input  logic [31:0]                instr,
   input  logic                       pc_zero,
   output logic                       alu_src_a,
   output logic [1:0]                 alu_src_b,
   output logic                       zero_ext,
   output logic                       i_or_d,
   output logic                       ir_write,
   output logic                       pc_write,
   output logic                       reg_write,
   output logic [1:0]                 pc_source,
   output logic                       reg_dst,
   output logic                       mem_to_reg,
   output logic                       active
);

   state_e     state_q, state_d;
   alu_op_e    alu_op;
   alu_op_e    fn_op;
   logic       fn_valid;
   logic [5:0] opcode;
   logic [5:0] funct;

   logic is_rtype, is_jr, is_ralu, is_lw, is_sw, is_mem;
   logic is_addiu, is_slti, is_andi, is_ori, is_imm;
   logic is_beq, is_bne, is_j, halt_fetch;

   assign opcode = instr[31:26];
   assign funct  = instr[5:0];

   alu_op_decoder u_alu_op_decoder (
      .funct (funct),
      .op    (fn_op),
      .valid (fn_valid)
   );

   assign is_rtype = (opcode == OpRtype);
   assign is_jr    = is_rtype && (funct == FnJr);
   assign is_ralu  = is_rtype && fn_valid;
   assign is_lw    = (opcode == OpLw);
   assign is_sw    = (opcode == OpSw);
   assign is_mem   = is_lw || is_sw;
   assign is_addiu = (opcode == OpAddiu);
   assign is_slti  = (opcode == OpSlti);
   assign is_andi  = (opcode == OpAndi);
   assign is_ori   = (opcode == OpOri);
   assign is_imm   = is_addiu || is_slti || is_andi || is_ori;
   assign is_beq   = (opcode == OpBeq);
   assign is_bne   = (opcode == OpBne);
   assign is_j     = (opcode == OpJ);

   // A fetch from address zero is treated as end of program
   assign halt_fetch = RESET_VECTOR_ZERO_HALT && pc_zero;

   // State register with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StFetch;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         StFetch: begin
            if (halt_fetch) begin
               state_d = StHalt;
            end else if (!bus.waitrequest) begin
               state_d = StDecode;
            end
         end
         StDecode: state_d = StExec;
         StExec: begin
            if (is_ralu || is_imm) begin
               state_d = StWb;
            end else if (is_mem) begin
               state_d = StMem;
            end else begin
               state_d = StFetch;
            end
         end
         StMem: begin
            if (!bus.waitrequest) begin
               state_d = is_lw ? StWb : StFetch;
            end
         end
         StWb:    state_d = StFetch;
         StHalt:  state_d = StHalt;
         default: state_d = StFetch;
      endcase
   end

   // Output decode; reset forces defaults so an in-flight access is dropped
   always_comb begin
      alu_op     = AluAdd;
      alu_src_a  = 1'b0;
      alu_src_b  = SrcBRegB;
      zero_ext   = 1'b0;
      i_or_d     = 1'b0;
      bus.read   = 1'b0;
      bus.write  = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      pc_source  = PcSrcAlu;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      active     = 1'b1;
      if (reset) begin
         active = 1'b0;
      end else begin
         case (state_q)
            StFetch: begin
               if (!halt_fetch) begin
                  bus.read  = 1'b1;
                  alu_src_b = SrcBFour;
                  if (!bus.waitrequest) begin
                     ir_write = 1'b1;
                     pc_write = 1'b1;
                  end
               end
            end
            StDecode: begin
               // Branch target PC + (imm << 2) lands in ALUOut
               alu_src_b = SrcBImmSh;
            end
            StExec: begin
               if (is_ralu) begin
                  alu_src_a = 1'b1;
                  alu_op    = fn_op;
               end else if (is_jr) begin
                  pc_write  = 1'b1;
                  pc_source = PcSrcRegA;
               end else if (is_addiu || is_slti) begin
                  alu_src_a = 1'b1;
                  alu_src_b = SrcBImm;
                  alu_op    = is_slti ? AluSlt : AluAdd;
               end else if (is_andi || is_ori) begin
                  alu_src_a = 1'b1;
                  alu_src_b = SrcBImm;
                  zero_ext  = 1'b1;
                  alu_op    = is_ori ? AluOr : AluAnd;
               end else if (is_mem) begin
                  alu_src_a = 1'b1;
                  alu_src_b = SrcBImm;
               end else if (is_beq || is_bne) begin
                  alu_src_a = 1'b1;
                  alu_op    = AluSub;
                  pc_write  = is_beq ? bus.zero : !bus.zero;
                  pc_source = PcSrcAluOut;
               end else if (is_j) begin
                  pc_write  = 1'b1;
                  pc_source = PcSrcJump;
               end
            end
            StMem: begin
               i_or_d    = 1'b1;
               bus.read  = is_lw;
               bus.write = is_sw;
            end
            StWb: begin
               reg_write  = 1'b1;
               reg_dst    = is_rtype;
               mem_to_reg = is_lw;
            end
            StHalt: begin
               active = 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.alu_operation = alu_op;

endmodule

// File: tb/tb_mips_control_fsm.sv
// Directed-vector bench for the multi-cycle MIPS control unit.
module tb_mips_control_fsm;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instr;
   logic        pc_zero;
   logic        alu_src_a;
   logic [1:0]  alu_src_b;
   logic        zero_ext;
   logic        i_or_d;
   logic        ir_write;
   logic        pc_write;
   logic        reg_write;
   logic [1:0]  pc_source;
   logic        reg_dst;
   logic        mem_to_reg;
   logic        active;

   int checks   = 0;
   int failures = 0;

   localparam logic [31:0] InsAddu = 32'h0022_1821; // addu $3,$1,$2
   localparam logic [31:0] InsBeq  = 32'h1022_0004; // beq  $1,$2,4
   localparam logic [31:0] InsBne  = 32'h1422_0004; // bne  $1,$2,4
   localparam logic [31:0] InsLw   = 32'h8C22_0008; // lw   $2,8($1)
   localparam logic [31:0] InsOri  = 32'h3402_FFFF; // ori  $2,$0,0xFFFF
   localparam logic [31:0] InsSw   = 32'hAC22_0008; // sw   $2,8($1)
   localparam logic [31:0] InsJ    = 32'h0800_0010; // j    0x40
   localparam logic [31:0] InsJr   = 32'h03E0_0008; // jr   $31

   mips_control_fsm_if bus ();

   mips_control_fsm #(
      .RESET_VECTOR_ZERO_HALT (1'b1)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .instr      (instr),
      .pc_zero    (pc_zero),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .zero_ext   (zero_ext),
      .i_or_d     (i_or_d),
      .ir_write   (ir_write),
      .pc_write   (pc_write),
      .reg_write  (reg_write),
      .pc_source  (pc_source),
      .reg_dst    (reg_dst),
      .mem_to_reg (mem_to_reg),
      .active     (active)
   );

   always #5 clk = ~clk;

   // {read, write, ir_write, pc_write, reg_write}
   function automatic logic [4:0] strobes();
      return {bus.read, bus.write, ir_write, pc_write, reg_write};
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Completes a zero-wait fetch and advances into DECODE with the given word
   task automatic fetch_decode(input string tag, input logic [31:0] word);
      bus.waitrequest = 1'b0;
      #2;
      check_eq({tag, "_fetch_strobes"}, 32'(strobes()), 32'b10110);
      check_eq({tag, "_fetch_pcsrc"}, 32'(pc_source), 32'd0);
      tick();
      instr = word;
      #2;
      check_eq({tag, "_dec_srcb"}, 32'(alu_src_b), 32'd3);
      check_eq({tag, "_dec_strobes"}, 32'(strobes()), 32'd0);
   endtask

   initial begin
      reset           = 1'b1;
      instr           = 32'd0;
      pc_zero         = 1'b0;
      bus.zero        = 1'b0;
      bus.waitrequest = 1'b0;

      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("rst_active", 32'(active), 32'd0);
         check_eq("rst_strobes", 32'(strobes()), 32'd0);
      end

      // First fetch after reset, stalled two cycles
      reset           = 1'b0;
      bus.waitrequest = 1'b1;
      #2;
      check_eq("fetch1_active", 32'(active), 32'd1);
      check_eq("fetch1_strobes", 32'(strobes()), 32'b10000);
      check_eq("fetch1_iord", 32'(i_or_d), 32'd0);
      check_eq("fetch1_aluop", 32'(bus.alu_operation), 32'b0010);
      check_eq("fetch1_srcb", 32'(alu_src_b), 32'd1);
      tick();
      #2;
      check_eq("fetch2_strobes", 32'(strobes()), 32'b10000);
      tick();

      // addu: third fetch cycle releases the stall
      fetch_decode("addu", InsAddu);
      tick();
      #2;
      check_eq("addu_exec_aluop", 32'(bus.alu_operation), 32'b0010);
      check_eq("addu_exec_srca", 32'(alu_src_a), 32'd1);
      check_eq("addu_exec_srcb", 32'(alu_src_b), 32'd0);
      check_eq("addu_exec_strobes", 32'(strobes()), 32'd0);
      tick();
      #2;
      check_eq("addu_wb_strobes", 32'(strobes()), 32'b00001);
      check_eq("addu_wb_regdst", 32'(reg_dst), 32'd1);
      check_eq("addu_wb_memtoreg", 32'(mem_to_reg), 32'd0);
      tick();

      // beq taken
      fetch_decode("beq", InsBeq);
      tick();
      bus.zero = 1'b1;
      #2;
      check_eq("beq_exec_pcwrite", 32'(pc_write), 32'd1);
      check_eq("beq_exec_pcsrc", 32'(pc_source), 32'd1);
      check_eq("beq_exec_aluop", 32'(bus.alu_operation), 32'b0110);
      check_eq("beq_exec_srca", 32'(alu_src_a), 32'd1);
      tick();

      // bne not taken with zero=1
      fetch_decode("bne", InsBne);
      tick();
      #2;
      check_eq("bne_exec_pcwrite", 32'(pc_write), 32'd0);
      check_eq("bne_exec_aluop", 32'(bus.alu_operation), 32'b0110);
      tick();
      bus.zero = 1'b0;

      // lw with one memory wait cycle
      fetch_decode("lw", InsLw);
      tick();
      #2;
      check_eq("lw_exec_aluop", 32'(bus.alu_operation), 32'b0010);
      check_eq("lw_exec_srcb", 32'(alu_src_b), 32'd2);
      check_eq("lw_exec_strobes", 32'(strobes()), 32'd0);
      tick();
      bus.waitrequest = 1'b1;
      #2;
      check_eq("lw_mem1_strobes", 32'(strobes()), 32'b10000);
      check_eq("lw_mem1_iord", 32'(i_or_d), 32'd1);
      tick();
      bus.waitrequest = 1'b0;
      #2;
      check_eq("lw_mem2_strobes", 32'(strobes()), 32'b10000);
      tick();
      #2;
      check_eq("lw_wb_strobes", 32'(strobes()), 32'b00001);
      check_eq("lw_wb_memtoreg", 32'(mem_to_reg), 32'd1);
      check_eq("lw_wb_regdst", 32'(reg_dst), 32'd0);
      tick();

      // ori with zero-extended immediate
      fetch_decode("ori", InsOri);
      tick();
      #2;
      check_eq("ori_exec_aluop", 32'(bus.alu_operation), 32'b0001);
      check_eq("ori_exec_zext", 32'(zero_ext), 32'd1);
      check_eq("ori_exec_srcb", 32'(alu_src_b), 32'd2);
      tick();
      #2;
      check_eq("ori_wb_strobes", 32'(strobes()), 32'b00001);
      check_eq("ori_wb_regdst", 32'(reg_dst), 32'd0);
      tick();

      // sw stalled in MEM, then aborted by reset
      fetch_decode("sw", InsSw);
      tick();
      bus.waitrequest = 1'b1;
      tick();
      #2;
      check_eq("sw_mem1_strobes", 32'(strobes()), 32'b01000);
      check_eq("sw_mem1_iord", 32'(i_or_d), 32'd1);
      tick();
      #2;
      check_eq("sw_mem2_strobes", 32'(strobes()), 32'b01000);
      reset = 1'b1;
      #1;
      check_eq("sw_rst_strobes", 32'(strobes()), 32'd0);
      check_eq("sw_rst_active", 32'(active), 32'd0);
      tick();
      reset = 1'b0;

      // j, restarted from a clean fetch
      fetch_decode("j", InsJ);
      tick();
      #2;
      check_eq("j_exec_pcwrite", 32'(pc_write), 32'd1);
      check_eq("j_exec_pcsrc", 32'(pc_source), 32'd2);
      tick();

      // jr to address zero, then halt
      fetch_decode("jr", InsJr);
      tick();
      #2;
      check_eq("jr_exec_strobes", 32'(strobes()), 32'b00010);
      check_eq("jr_exec_pcsrc", 32'(pc_source), 32'd3);
      tick();
      pc_zero = 1'b1;
      #2;
      check_eq("halt_fetch_strobes", 32'(strobes()), 32'd0);
      for (int i = 0; i < 20; i++) begin
         tick();
         #2;
         check_eq("halt_active", 32'(active), 32'd0);
         check_eq("halt_strobes", 32'(strobes()), 32'd0);
      end

      // Reset leaves HALT
      reset = 1'b1;
      tick();
      reset   = 1'b0;
      pc_zero = 1'b0;
      #2;
      check_eq("post_halt_active", 32'(active), 32'd1);
      check_eq("post_halt_strobes", 32'(strobes()), 32'b10110);
      check_eq("post_halt_iord", 32'(i_or_d), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
